// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the scoreboarded register file
package regfile_pkg;

  // Default geometry of the register file.
  localparam int WORDSIZE_DEF = 64;
  localparam int SIZE_DEF     = 32;

  // Register 0 is hardwired to zero and is never pending.
  localparam int ZERO_REG = 0;

  // Register address for the default geometry.
  typedef logic [$clog2(SIZE_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits, pending count and double-reserve error
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int AW   = $clog2(SIZE),
  parameter int CW   = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [SIZE-1:0] pending,
  output logic [CW-1:0]   pend_count,
  output logic            rsv_err
);

  logic            wr_hit;
  logic            rsv_hit;
  logic            same_addr;
  logic            set_new;
  logic            clr_old;
  logic            err_next;
  logic [SIZE-1:0] pending_next;
  logic [CW-1:0]   count_next;

  // Qualify strobes (register 0 is invisible) and derive the next pending state.
  // A write and a reserve to the same register on one edge is a clean
  // re-allocation: the bit stays/ends set and no error is flagged.
  always_comb begin
    wr_hit    = wr_en  && (wr_addr  != AW'(ZERO_REG));
    rsv_hit   = rsv_en && (rsv_addr != AW'(ZERO_REG));
    same_addr = wr_hit && rsv_hit && (wr_addr == rsv_addr);

    set_new   = rsv_hit && !pending[rsv_addr];
    clr_old   = wr_hit && pending[wr_addr] && !same_addr;
    err_next  = rsv_hit && pending[rsv_addr] && !same_addr;

    pending_next = pending;
    if (wr_hit) begin
      pending_next[wr_addr] = 1'b0;
    end
    if (rsv_hit) begin
      pending_next[rsv_addr] = 1'b1;
    end
  end

  // Track the population count incrementally from the 0->1 and 1->0 transitions.
  always_comb begin
    count_next = pend_count;
    case ({set_new, clr_old})
      2'b10:   count_next = pend_count + CW'(1);
      2'b01:   count_next = pend_count - CW'(1);
      default: count_next = pend_count;
    endcase
  end

  // Pending state, count and one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      pend_count <= '0;
      rsv_err    <= 1'b0;
    end else begin
      pending    <= pending_next;
      pend_count <= count_next;
      rsv_err    <= err_next;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with scoreboard; optional bypass via REGFILE_SB_BYPASS_EN
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int SIZE     = SIZE_DEF,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(SIZE),
  parameter int CW       = $clog2(SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WORDSIZE-1:0]      wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WORDSIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic [CW-1:0]            pend_count,
  output logic                     rsv_err
);

  logic [WORDSIZE-1:0] mem [SIZE];
  logic [SIZE-1:0]     pending;
  logic [WORDSIZE-1:0] port_data  [NUM_RD];
  logic [NUM_RD-1:0]   port_ready;

  regfile_scoreboard #(
    .SIZE (SIZE),
    .AW   (AW),
    .CW   (CW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .pending    (pending),
    .pend_count (pend_count),
    .rsv_err    (rsv_err)
  );

  // Data array: cleared by reset, register 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Independent combinational read ports with optional write-to-read forwarding.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = rd_addr[k*AW +: AW];

    // Select stored value and readiness for this port, forwarding the write when enabled.
    always_comb begin
      port_data[k]  = mem[sel];
      port_ready[k] = !pending[sel];
      if (sel == AW'(ZERO_REG)) begin
        port_data[k]  = '0;
        port_ready[k] = 1'b1;
      end
`ifdef REGFILE_SB_BYPASS_EN
      else if (wr_en && (wr_addr == sel)) begin
        port_data[k] = wr_data;
        // A same-cycle reserve of this register means the forwarded value is
        // already superseded by a new producer, so readiness stays as stored.
        if (!(rsv_en && (rsv_addr == sel))) begin
          port_ready[k] = 1'b1;
        end
      end
`endif
    end
  end

  // Pack per-port results onto the flat output buses.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*WORDSIZE +: WORDSIZE] = port_data[k];
      rd_ready[k]                     = port_ready[k];
    end
  end

endmodule
